// File: rtl/alsu_pkg.sv
// alsu shared encodings: Sel fields and FSM states.
// Imported by the datapath and the sequencer.
package alsu_pkg;

  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_LOGIC = 2'b01;
  localparam logic [1:0] OP_SHR   = 2'b10;
  localparam logic [1:0] OP_SHL   = 2'b11;
  localparam logic [1:0] SUB_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_mul(input logic [3:0] sel);
    return sel[3] & (sel[1:0] == SUB_MUL);
  endfunction

endpackage

// File: rtl/alsu_comb.sv
// Single-cycle arithmetic/logic datapath.
// Produces F, carry and signed overflow.
module alsu_comb
  import alsu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] f,
  output logic             co,
  output logic             v
);

  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;

  always_comb begin
    y = '0;
    unique case (sel[1:0])
      2'b00:   y = '0;
      2'b01:   y = b;
      2'b10:   y = ~b;
      default: y = '1;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, y}
             + {{WIDTH{1'b0}}, ci};

  always_comb begin
    f  = '0;
    co = 1'b0;
    v  = 1'b0;
    if (sel[3:2] == OP_ARITH) begin
      f  = sum[WIDTH-1:0];
      co = sum[WIDTH];
      v  = (a[WIDTH-1] == y[WIDTH-1])
         & (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (sel[3:2] == OP_LOGIC) begin
      unique case (sel[1:0])
        2'b00:   f = a & b;
        2'b01:   f = a | b;
        2'b10:   f = a ^ b;
        default: f = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alsu_seq.sv
// Sequential ALSU: handshakes, serial shifts, shift-add multiply.
// The first shift/multiply step runs on the acceptance edge.
module alsu_seq
  import alsu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Ir,
  input  logic             IL,
  input  logic [SW-1:0]    ShAmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Co,
  output logic             Z,
  output logic             N,
  output logic             V
);

  state_t state, state_n;

  logic [3:0]         sel_q;
  logic [WIDTH-1:0]   a_q;
  logic               ir_q, il_q;
  logic [SW-1:0]      cnt;
  logic [WIDTH-1:0]   w;
  logic [2*WIDTH-1:0] acc;

  logic               go, load, single, last, step;
  logic               mul_op;
  logic [3:0]         c_sel;
  logic [WIDTH-1:0]   c_a;
  logic               c_ir, c_il;
  logic [SW-1:0]      rem0;

  logic [WIDTH-1:0]   sh_src, sh_nxt;
  logic               sh_out, fill;
  logic [2*WIDTH-1:0] acc_src, acc_nxt;
  logic [WIDTH:0]     psum;

  logic [WIDTH-1:0]   cf;
  logic               cco, cv;
  logic [WIDTH-1:0]   res_f;
  logic               res_co, res_v;

  alsu_comb #(.WIDTH(WIDTH)) u_comb (
    .sel (Sel),
    .a   (A),
    .b   (B),
    .ci  (Ci),
    .f   (cf),
    .co  (cco),
    .v   (cv)
  );

  assign in_ready  = (state == IDLE)
                   | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign go        = in_valid & in_ready;

  assign c_sel  = go ? Sel : sel_q;
  assign c_a    = go ? A   : a_q;
  assign c_ir   = go ? Ir  : ir_q;
  assign c_il   = go ? IL  : il_q;
  assign mul_op = is_mul(c_sel);

  assign single = go & (~Sel[3]
                | (~is_mul(Sel) & (ShAmt == '0)));
  assign rem0   = is_mul(Sel) ? SW'(WIDTH - 1)
                              : ShAmt - 1'b1;
  assign last   = go ? (rem0 == '0) : (cnt == SW'(1));
  assign step   = go | (state == BUSY);

  // one serial shift step; sh_out is the exiting bit
  assign sh_src = go ? A : w;

  always_comb begin
    fill   = 1'b0;
    sh_out = 1'b0;
    sh_nxt = sh_src;
    if (c_sel[2]) begin
      sh_out = sh_src[WIDTH-1];
      fill   = c_sel[1] ? sh_src[WIDTH-1] : c_il;
      sh_nxt = {sh_src[WIDTH-2:0], fill};
    end else begin
      sh_out = sh_src[0];
      unique case (c_sel[1:0])
        2'b00:   fill = c_ir;
        2'b01:   fill = sh_src[WIDTH-1];
        default: fill = sh_src[0];
      endcase
      sh_nxt = {fill, sh_src[WIDTH-1:1]};
    end
  end

  // {hi, lo}: lo starts as B and is consumed LSB first
  assign acc_src = go ? {{WIDTH{1'b0}}, B} : acc;
  assign psum    = {1'b0, acc_src[2*WIDTH-1:WIDTH]}
                 + (acc_src[0] ? {1'b0, c_a}
                               : {(WIDTH+1){1'b0}});
  assign acc_nxt = {psum, acc_src[WIDTH-1:1]};

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if ((state == DONE) && out_ready)
          state_n = IDLE;
        if (go) begin
          if (single || last) begin
            state_n = DONE;
            load    = 1'b1;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (last) begin
          state_n = DONE;
          load    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    res_f  = sh_nxt;
    res_co = sh_out;
    res_v  = 1'b0;
    unique case (1'b1)
      single & ~Sel[3]: begin
        res_f  = cf;
        res_co = cco;
        res_v  = cv;
      end
      single & Sel[3]: begin
        res_f  = A;
        res_co = 1'b0;
      end
      mul_op: begin
        res_f  = acc_nxt[WIDTH-1:0];
        res_co = |acc_nxt[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= '0;
      a_q   <= '0;
      ir_q  <= 1'b0;
      il_q  <= 1'b0;
      cnt   <= '0;
      w     <= '0;
      acc   <= '0;
      F     <= '0;
      Co    <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
    end else begin
      state <= state_n;
      if (go) begin
        sel_q <= Sel;
        a_q   <= A;
        ir_q  <= Ir;
        il_q  <= IL;
      end
      if (step) begin
        w   <= sh_nxt;
        acc <= acc_nxt;
        cnt <= go ? rem0 : cnt - 1'b1;
      end
      if (load) begin
        F  <= res_f;
        Co <= res_co;
        V  <= res_v;
        Z  <= (res_f == '0);
        N  <= res_f[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alsu_seq.sv
// Bench for alsu_seq: directed vectors, scoreboard model,
// backpressure and mid-multiply reset.
module tb_alsu_seq;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk, rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    Sel;
  logic [W-1:0]  A, B;
  logic          Ci, Ir, IL;
  logic [SW-1:0] ShAmt;
  logic          out_valid, out_ready;
  logic [W-1:0]  F;
  logic          Co, Z, N, V;

  alsu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sel       (Sel),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .Ir        (Ir),
    .IL        (IL),
    .ShAmt     (ShAmt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .Co        (Co),
    .Z         (Z),
    .N         (N),
    .V         (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [W-1:0] f;
    logic         co, v;
    int           lat;
  } res_t;

  // result straight from the operation definitions
  function automatic res_t model(
    input logic [3:0] s, input logic [W-1:0] a,
    input logic [W-1:0] b, input logic ci,
    input logic ir, input logic il, input int k);
    res_t r;
    logic [W:0]     sum;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
    r.f = '0; r.co = 0; r.v = 0; r.lat = 1;
    if (s[3:2] == 2'b00) begin
      case (s[1:0])
        2'b00:   y = '0;
        2'b01:   y = b;
        2'b10:   y = ~b;
        default: y = '1;
      endcase
      sum  = (W+1)'(a) + (W+1)'(y) + (W+1)'(ci);
      r.f  = sum[W-1:0];
      r.co = sum[W];
      r.v  = (a[W-1] == y[W-1]) && (r.f[W-1] != a[W-1]);
    end else if (s[3:2] == 2'b01) begin
      case (s[1:0])
        2'b00:   r.f = a & b;
        2'b01:   r.f = a | b;
        2'b10:   r.f = a ^ b;
        default: r.f = ~a;
      endcase
    end else if (s[1:0] == 2'b11) begin
      p     = (2*W)'(a) * (2*W)'(b);
      r.f   = p[W-1:0];
      r.co  = (p[2*W-1:W] != 0);
      r.lat = W;
    end else if (k == 0) begin
      r.f = a;
    end else begin
      r.lat = k;
      if (!s[2]) begin
        r.co = a[k-1];
        case (s[1:0])
          2'b00: r.f = (a >> k)
                     | (ir ? ~(8'hFF >> k) : 8'h00);
          2'b01: r.f = W'($signed(a) >>> k);
          default: r.f = (a >> k) | (a << (W - k));
        endcase
      end else begin
        r.co = a[W-k];
        if (s[1]) r.f = (a << k) | (a >> (W - k));
        else      r.f = (a << k)
                      | (il ? ~(8'hFF << k) : 8'h00);
      end
    end
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] f;
    logic         co, v, z, n;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  logic [W-1:0] hold_f  = '0;
  logic [3:0]   hold_fl = '0;

  always @(posedge clk) cyc++;

  // scoreboard: every cycle outside reset
  always @(negedge clk) begin
    logic due, exp_rdy;
    res_t r;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_f  = '0;
      hold_fl = '0;
    end else begin
      due     = (q.size() > 0) && (q[0].due <= cyc);
      exp_rdy = (q.size() == 0) || (due && out_ready);
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, due);
      if (due) begin
        chk("F", F, q[0].f);
        chk("flags", {Co, Z, N, V},
            {q[0].co, q[0].z, q[0].n, q[0].v});
        hold_f  = q[0].f;
        hold_fl = {q[0].co, q[0].z, q[0].n, q[0].v};
        if (out_ready) void'(q.pop_front());
      end else begin
        chk("F_hold", F, hold_f);
        chk("flags_hold", {Co, Z, N, V}, hold_fl);
      end
      if (in_valid && exp_rdy) begin
        r     = model(Sel, A, B, Ci, Ir, IL, int'(ShAmt));
        e.f   = r.f;
        e.co  = r.co;
        e.v   = r.v;
        e.z   = (r.f == 0);
        e.n   = r.f[W-1];
        e.due = cyc + r.lat;
        q.push_back(e);
      end
    end
  end

  typedef struct {
    logic [3:0]    sel;
    logic [W-1:0]  a, b;
    logic          ci, ir, il;
    logic [SW-1:0] sh;
    logic [W-1:0]  f;
    logic          co, v, z, n;
    int            lat;
  } vec_t;

  vec_t tv[16];

  task automatic run_op(input int i);
    int k;
    vec_t t;
    t = tv[i];
    @(posedge clk); #2;
    Sel = t.sel; A = t.a; B = t.b;
    Ci = t.ci; Ir = t.ir; IL = t.il; ShAmt = t.sh;
    in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!in_ready && k < 50);
    chk($sformatf("v%0d_accept", i), in_ready, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    A = ~t.a; B = ~t.b; Ci = ~t.ci;
    Ir = ~t.ir; IL = ~t.il; ShAmt = ~t.sh;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!out_valid && k < 60);
    chk($sformatf("v%0d_lat", i), k, t.lat);
    chk($sformatf("v%0d_F", i), F, t.f);
    chk($sformatf("v%0d_CoVZN", i), {Co, V, Z, N},
        {t.co, t.v, t.z, t.n});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    //         sel      a      b    ci ir il sh  f    co v  z  n lat
    tv[0]  = '{4'b0001, 8'h05, 8'h03, 1, 0, 0, 0, 8'h09, 0, 0, 0, 0, 1};
    tv[1]  = '{4'b0010, 8'h05, 8'h03, 1, 0, 0, 0, 8'h02, 1, 0, 0, 0, 1};
    tv[2]  = '{4'b0001, 8'h7F, 8'h01, 0, 0, 0, 0, 8'h80, 0, 1, 0, 1, 1};
    tv[3]  = '{4'b1001, 8'h90, 8'h00, 0, 0, 0, 3, 8'hF2, 0, 0, 0, 1, 3};
    tv[4]  = '{4'b1110, 8'h81, 8'h00, 0, 0, 0, 1, 8'h03, 1, 0, 0, 0, 1};
    tv[5]  = '{4'b1011, 8'h0F, 8'h11, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 8};
    tv[6]  = '{4'b1011, 8'h10, 8'h10, 0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8};
    tv[7]  = '{4'b0110, 8'hAA, 8'hAA, 1, 1, 1, 0, 8'h00, 0, 0, 1, 0, 1};
    tv[8]  = '{4'b0111, 8'h0F, 8'h00, 0, 0, 0, 0, 8'hF0, 0, 0, 0, 1, 1};
    tv[9]  = '{4'b0011, 8'h00, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 1};
    tv[10] = '{4'b1000, 8'h01, 8'h00, 0, 1, 0, 2, 8'hC0, 0, 0, 0, 1, 2};
    tv[11] = '{4'b1100, 8'h81, 8'h00, 0, 0, 1, 4, 8'h1F, 0, 0, 0, 0, 4};
    tv[12] = '{4'b1010, 8'h01, 8'h00, 0, 0, 0, 7, 8'h02, 0, 0, 0, 0, 7};
    tv[13] = '{4'b1101, 8'h5A, 8'h00, 0, 0, 1, 0, 8'h5A, 0, 0, 0, 0, 1};
    tv[14] = '{4'b0000, 8'hFF, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 1, 0, 1};
    tv[15] = '{4'b1011, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h01, 1, 0, 0, 0, 8};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Sel = '0; A = '0; B = '0; Ci = 0; Ir = 0; IL = 0;
    ShAmt = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_F", F, 0);
    chk("rst_flags", {Co, Z, N, V}, 0);

    for (int i = 0; i < 16; i++) run_op(i);

    // backpressure, then consume and accept at one edge
    @(posedge clk); #2;
    Sel = 4'b0001; A = 8'h10; B = 8'h20; Ci = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept", in_ready, 1);
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_F", F, 8'h30);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_F", F, 8'h30);
      chk("bp_hold_fl", {Co, Z, N, V}, 4'b0000);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1; in_valid = 1'b1;
    Sel = 4'b0010; A = 8'h30; B = 8'h10; Ci = 1;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_F", F, 8'h20);
    chk("b2b_Co", Co, 1);

    // reset in the middle of a multiply
    @(posedge clk); #2;
    Sel = 4'b1011; A = 8'h03; B = 8'h05;
    in_valid = 1'b1;
    @(negedge clk);
    chk("mr_accept", in_ready, 1);
    @(posedge clk); #2 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_F", F, 0);
    chk("mr_flags", {Co, Z, N, V}, 0);
    chk("mr_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mr_no_result", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
